// File: rtl/debug_mode_pkg.sv
// rtl/debug_mode_pkg.sv - shared types and constants for the debug-mode tracker
// Purpose: state enum, debug-entry cause codes, debug CSR addresses and dcsr
//          field layout used by debug_mode_state_tracker and debug_csr_regs.
// Ports:   none (package).
package debug_mode_pkg;

  typedef enum logic [1:0] {
    ST_RUNNING  = 2'd0,
    ST_DEBUG    = 2'd1,
    ST_STEPPING = 2'd2
  } dbg_state_e;

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_TRIGGER = 3'd2;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

  localparam logic [11:0] CSR_DCSR      = 12'h7B0;
  localparam logic [11:0] CSR_DPC       = 12'h7B1;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] CSR_DSCRATCH1 = 12'h7B3;

  localparam int DCSR_STEP_BIT  = 2;
  localparam int DCSR_CAUSE_LSB = 6;

  localparam logic [63:0] DCSR_WMASK     = 64'h0000_0000_0000_BE07;
  localparam logic [63:0] DCSR_XDEBUGVER = 64'h0000_0000_4000_0000;
  localparam logic [63:0] DCSR_RESET     = 64'h0000_0000_4000_0003;

  // Privilege encoding 2 is reserved; a dcsr write carrying it keeps prv.
  localparam logic [1:0] PRV_RESERVED = 2'd2;

  // Unknown entry causes collapse to ebreak.
  function automatic logic [2:0] norm_enter_cause(input logic [2:0] c);
    return (c == CAUSE_TRIGGER) ? CAUSE_TRIGGER : CAUSE_EBREAK;
  endfunction

endpackage

// File: rtl/debug_csr_regs.sv
// rtl/debug_csr_regs.sv - dcsr/dpc/dscratch0/dscratch1 storage with write masking
// Purpose: holds the four debug CSRs; applies qualified CSR writes and the
//          entry-time update of dcsr.cause, dcsr.prv and dpc.
// Ports:   clock, reset_n         - clock, async active-low reset
//          csr_wen/addr/wdata     - CSR write, already qualified to DEBUG
//          enter_en/cause/dpc/prv - debug entry update (never with csr_wen)
//          dcsr, dpc, dscratch0/1 - current register values
module debug_csr_regs
  import debug_mode_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        csr_wen,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_wdata,
  input  logic        enter_en,
  input  logic [2:0]  enter_cause,
  input  logic [63:0] enter_dpc,
  input  logic [1:0]  enter_prv,
  output logic [63:0] dcsr,
  output logic [63:0] dpc,
  output logic [63:0] dscratch0,
  output logic [63:0] dscratch1
);

  // ctrl_q holds only the writable dcsr bits; cause and xdebugver are merged
  // on the read side so read-only fields can never be corrupted by a write.
  logic [63:0] ctrl_q;
  logic [2:0]  cause_q;
  logic [63:0] ctrl_wr;

  always_comb begin
    ctrl_wr = csr_wdata & DCSR_WMASK;
    if (csr_wdata[1:0] == PRV_RESERVED) begin
      ctrl_wr[1:0] = ctrl_q[1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= DCSR_RESET & DCSR_WMASK;
      cause_q   <= 3'd0;
      dpc       <= 64'd0;
      dscratch0 <= 64'd0;
      dscratch1 <= 64'd0;
    end else begin
      if (enter_en) begin
        cause_q     <= enter_cause;
        ctrl_q[1:0] <= enter_prv;
        dpc         <= enter_dpc;
      end
      if (csr_wen) begin
        case (csr_addr)
          CSR_DCSR:      ctrl_q    <= ctrl_wr;
          CSR_DPC:       dpc       <= {csr_wdata[63:1], 1'b0};
          CSR_DSCRATCH0: dscratch0 <= csr_wdata;
          CSR_DSCRATCH1: dscratch1 <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  assign dcsr = DCSR_XDEBUGVER | ctrl_q | (64'(cause_q) << DCSR_CAUSE_LSB);

endmodule

// File: rtl/debug_mode_state_tracker.sv
// rtl/debug_mode_state_tracker.sv - per-hart RISC-V debug-mode state tracker
// Purpose: sequences halt / resume / single-step from core events and the
//          debug-module halt request; exports debug CSR snapshots every cycle.
// Ports:   clock, reset_n                 - clock, async active-low reset
//          io_coreid -> io_coreid_o       - hart id, registered
//          io_haltreq, io_enter_*         - halt request and ebreak/trigger entry
//          io_retire_*, io_priv, io_dret_valid - core retire / privilege / dret
//          io_csr_*                       - CSR write port
//          io_halt_ack, io_resume_*       - entry / exit pulses and resume info
//          io_debugMode, io_dcsr, io_dpc, io_dscratch0/1 - state snapshot
module debug_mode_state_tracker
  import debug_mode_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  io_coreid,
  input  logic        io_haltreq,
  input  logic        io_enter_valid,
  input  logic [2:0]  io_enter_cause,
  input  logic [63:0] io_enter_pc,
  input  logic        io_retire_valid,
  input  logic [63:0] io_retire_npc,
  input  logic [1:0]  io_priv,
  input  logic        io_dret_valid,
  input  logic        io_csr_wen,
  input  logic [11:0] io_csr_addr,
  input  logic [63:0] io_csr_wdata,
  output logic        io_halt_ack,
  output logic        io_resume_valid,
  output logic [63:0] io_resume_pc,
  output logic [1:0]  io_resume_priv,
  output logic [7:0]  io_coreid_o,
  output logic        io_debugMode,
  output logic [63:0] io_dcsr,
  output logic [63:0] io_dpc,
  output logic [63:0] io_dscratch0,
  output logic [63:0] io_dscratch1
);

  dbg_state_e  state_q, state_d;
  logic        enter_en;
  logic [2:0]  enter_cause;
  logic [63:0] enter_dpc;
  logic        exit_en;
  logic        csr_wen_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUNNING;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUNNING, ST_STEPPING: if (enter_en) state_d = ST_DEBUG;
      // Step decision uses the pre-write dcsr, same as the resume info.
      ST_DEBUG: if (exit_en) state_d = io_dcsr[DCSR_STEP_BIT] ? ST_STEPPING : ST_RUNNING;
      default: state_d = ST_RUNNING;
    endcase
  end

  always_comb begin
    enter_en    = 1'b0;
    enter_cause = CAUSE_EBREAK;
    enter_dpc   = io_enter_pc;
    exit_en     = 1'b0;
    if (state_q == ST_DEBUG) begin
      exit_en = io_dret_valid;
    end else if (io_enter_valid) begin
      enter_en    = 1'b1;
      enter_cause = norm_enter_cause(io_enter_cause);
    end else if (io_retire_valid && io_haltreq) begin
      // Without a retire the halt request simply stays pending.
      enter_en    = 1'b1;
      enter_cause = CAUSE_HALTREQ;
      enter_dpc   = io_retire_npc;
    end else if (io_retire_valid && state_q == ST_STEPPING) begin
      enter_en    = 1'b1;
      enter_cause = CAUSE_STEP;
      enter_dpc   = io_retire_npc;
    end
  end

  assign csr_wen_q    = io_csr_wen && (state_q == ST_DEBUG);
  assign io_debugMode = (state_q == ST_DEBUG);

  debug_csr_regs u_csr_regs (
    .clock       (clock),
    .reset_n     (reset_n),
    .csr_wen     (csr_wen_q),
    .csr_addr    (io_csr_addr),
    .csr_wdata   (io_csr_wdata),
    .enter_en    (enter_en),
    .enter_cause (enter_cause),
    .enter_dpc   (enter_dpc),
    .enter_prv   (io_priv),
    .dcsr        (io_dcsr),
    .dpc         (io_dpc),
    .dscratch0   (io_dscratch0),
    .dscratch1   (io_dscratch1)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_halt_ack     <= 1'b0;
      io_resume_valid <= 1'b0;
      io_resume_pc    <= 64'd0;
      io_resume_priv  <= 2'd0;
      io_coreid_o     <= 8'd0;
    end else begin
      io_halt_ack     <= enter_en;
      io_resume_valid <= exit_en;
      io_coreid_o     <= io_coreid;
      if (exit_en) begin
        io_resume_pc   <= io_dpc;
        io_resume_priv <= io_dcsr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_debug_mode_state_tracker.sv
// tb/tb_debug_mode_state_tracker.sv - self-checking bench for debug_mode_state_tracker
module tb_debug_mode_state_tracker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  io_coreid;
  logic        io_haltreq;
  logic        io_enter_valid;
  logic [2:0]  io_enter_cause;
  logic [63:0] io_enter_pc;
  logic        io_retire_valid;
  logic [63:0] io_retire_npc;
  logic [1:0]  io_priv;
  logic        io_dret_valid;
  logic        io_csr_wen;
  logic [11:0] io_csr_addr;
  logic [63:0] io_csr_wdata;
  logic        io_halt_ack;
  logic        io_resume_valid;
  logic [63:0] io_resume_pc;
  logic [1:0]  io_resume_priv;
  logic [7:0]  io_coreid_o;
  logic        io_debugMode;
  logic [63:0] io_dcsr;
  logic [63:0] io_dpc;
  logic [63:0] io_dscratch0;
  logic [63:0] io_dscratch1;

  debug_mode_state_tracker dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .io_coreid       (io_coreid),
    .io_haltreq      (io_haltreq),
    .io_enter_valid  (io_enter_valid),
    .io_enter_cause  (io_enter_cause),
    .io_enter_pc     (io_enter_pc),
    .io_retire_valid (io_retire_valid),
    .io_retire_npc   (io_retire_npc),
    .io_priv         (io_priv),
    .io_dret_valid   (io_dret_valid),
    .io_csr_wen      (io_csr_wen),
    .io_csr_addr     (io_csr_addr),
    .io_csr_wdata    (io_csr_wdata),
    .io_halt_ack     (io_halt_ack),
    .io_resume_valid (io_resume_valid),
    .io_resume_pc    (io_resume_pc),
    .io_resume_priv  (io_resume_priv),
    .io_coreid_o     (io_coreid_o),
    .io_debugMode    (io_debugMode),
    .io_dcsr         (io_dcsr),
    .io_dpc          (io_dpc),
    .io_dscratch0    (io_dscratch0),
    .io_dscratch1    (io_dscratch1)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode flags plus individual dcsr fields.
  bit          m_dbg, m_stepping;
  logic [2:0]  m_cause;
  logic [1:0]  m_prv;
  logic [63:0] m_ctl;          // ebreak*/stepie/stop*/step bits only
  logic [63:0] m_dpc, m_ds0, m_ds1, m_rpc;
  logic [1:0]  m_rpriv;
  bit          m_ack, m_rv;
  logic [7:0]  m_core;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_dbg = 0; m_stepping = 0; m_cause = 0; m_prv = 3; m_ctl = 0;
    m_dpc = 0; m_ds0 = 0; m_ds1 = 0; m_rpc = 0; m_rpriv = 0;
    m_ack = 0; m_rv = 0; m_core = 0;
  endtask

  task automatic enter_debug(input logic [2:0] c, input logic [63:0] pc);
    m_cause = c; m_dpc = pc; m_prv = io_priv;
    m_dbg = 1; m_stepping = 0; m_ack = 1;
  endtask

  task automatic model_step();
    m_ack = 0; m_rv = 0;
    m_core = io_coreid;
    if (!m_dbg) begin
      if (io_enter_valid)                      enter_debug((io_enter_cause == 3'd2) ? 3'd2 : 3'd1, io_enter_pc);
      else if (io_haltreq && io_retire_valid)  enter_debug(3'd3, io_retire_npc);
      else if (m_stepping && io_retire_valid)  enter_debug(3'd4, io_retire_npc);
    end else begin
      bit step_pre;
      step_pre = m_ctl[2];
      if (io_dret_valid) begin
        m_rv = 1; m_rpc = m_dpc; m_rpriv = m_prv;
      end
      if (io_csr_wen) begin
        if (io_csr_addr == 12'h7B0) begin
          m_ctl = io_csr_wdata & 64'hBE04;
          if (io_csr_wdata[1:0] != 2'd2) m_prv = io_csr_wdata[1:0];
        end else if (io_csr_addr == 12'h7B1) m_dpc = io_csr_wdata & ~64'd1;
        else if (io_csr_addr == 12'h7B2) m_ds0 = io_csr_wdata;
        else if (io_csr_addr == 12'h7B3) m_ds1 = io_csr_wdata;
      end
      if (io_dret_valid) begin
        m_dbg = 0; m_stepping = step_pre;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] exp_dcsr;
    exp_dcsr = 64'h4000_0000 + (64'(m_cause) * 64) + m_ctl + 64'(m_prv);
    expect_eq("debugMode",    64'(io_debugMode),    64'(m_dbg));
    expect_eq("dcsr",         io_dcsr,              exp_dcsr);
    expect_eq("dpc",          io_dpc,               m_dpc);
    expect_eq("dscratch0",    io_dscratch0,         m_ds0);
    expect_eq("dscratch1",    io_dscratch1,         m_ds1);
    expect_eq("halt_ack",     64'(io_halt_ack),     64'(m_ack));
    expect_eq("resume_valid", 64'(io_resume_valid), 64'(m_rv));
    expect_eq("resume_pc",    io_resume_pc,         m_rpc);
    expect_eq("resume_priv",  64'(io_resume_priv),  64'(m_rpriv));
    expect_eq("coreid_o",     64'(io_coreid_o),     64'(m_core));
  endtask

  task automatic clear_inputs();
    io_haltreq = 0; io_enter_valid = 0; io_enter_cause = 0; io_enter_pc = 0;
    io_retire_valid = 0; io_retire_npc = 0; io_priv = 0; io_dret_valid = 0;
    io_csr_wen = 0; io_csr_addr = 0; io_csr_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d);
    clear_inputs();
    io_csr_wen = 1; io_csr_addr = a; io_csr_wdata = d;
    tick();
  endtask

  initial begin
    reset_n = 0;
    io_coreid = 8'h5A;
    clear_inputs();
    model_reset();
    #12;
    check_all();
    #1 reset_n = 1;

    // Halt request with retire.
    io_haltreq = 1; io_retire_valid = 1; io_retire_npc = 64'h8000_0010; io_priv = 0;
    tick();
    clear_inputs(); tick();

    csr_write(12'h7B0, 64'hFFFF_FFFF);
    csr_write(12'h7B1, 64'h1235);

    // Resume with step=1, then one retire re-enters with cause 4.
    clear_inputs(); io_dret_valid = 1; tick();
    clear_inputs(); io_retire_valid = 1; io_retire_npc = 64'h2000; io_priv = 1; tick();
    clear_inputs(); tick();

    // dret with a same-cycle dcsr write: write commits, step decision pre-write.
    clear_inputs(); io_dret_valid = 1; io_csr_wen = 1; io_csr_addr = 12'h7B0; io_csr_wdata = 64'h3; tick();

    // Simultaneous entry sources: ebreak wins.
    clear_inputs();
    io_enter_valid = 1; io_enter_cause = 3'd1; io_enter_pc = 64'h3000;
    io_haltreq = 1; io_retire_valid = 1; io_retire_npc = 64'h4000; io_priv = 3;
    tick();
    clear_inputs(); io_enter_valid = 1; io_enter_cause = 3'd2; tick();  // ignored in DEBUG
    clear_inputs(); io_dret_valid = 1; tick();
    csr_write(12'h7B2, 64'hDEAD_BEEF);                                 // ignored while RUNNING
    clear_inputs(); io_haltreq = 1; tick();                            // pending, no retire

    // Enter again, then pull reset in the middle of a CSR write.
    clear_inputs(); io_haltreq = 1; io_retire_valid = 1; io_retire_npc = 64'h9000; io_priv = 1; tick();
    csr_write(12'h7B3, 64'h1111);
    clear_inputs(); io_csr_wen = 1; io_csr_addr = 12'h7B2; io_csr_wdata = 64'h2222;
    #2 reset_n = 0;
    #1 model_reset(); check_all();
    clear_inputs();
    #1 reset_n = 1;
    csr_write(12'h7B3, 64'h3333);                                      // ignored after reset

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      clear_inputs();
      io_coreid       = 8'($urandom);
      io_haltreq      = ($urandom_range(0, 3) == 0);
      io_enter_valid  = ($urandom_range(0, 15) == 0);
      io_enter_cause  = 3'($urandom_range(0, 7));
      io_enter_pc     = {32'($urandom), 32'($urandom)};
      io_retire_valid = $urandom_range(0, 1) == 1;
      io_retire_npc   = {32'($urandom), 32'($urandom)};
      io_priv         = 2'($urandom);
      io_dret_valid   = ($urandom_range(0, 7) == 0);
      io_csr_wen      = ($urandom_range(0, 2) == 0);
      io_csr_addr     = ($urandom_range(0, 4) == 4) ? 12'h300 : 12'h7B0 + 12'($urandom_range(0, 3));
      io_csr_wdata    = {32'($urandom), 32'($urandom)};
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
